// File: rtl/cache_mem_bridge.sv
// cache_mem_bridge: splits 64 B cache line fills/writebacks into 16 x 32-bit memory bus beats.
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   req_rd/req_rd_addr               line fill request (level) and byte address
//   req_wr/req_wr_addr/req_wr_data   writeback request (level), byte address, victim line
//   busy                             transaction in progress
//   line_data/line_valid             assembled fill line and its one-cycle completion pulse
//   wr_done                          one-cycle writeback completion pulse
//   err                              one-cycle watchdog abort pulse
//   bus_valid/bus_we/bus_addr/bus_wdata/bus_ready   beat command channel
//   bus_rdata/bus_rvalid             in-order read response channel
// Optional: define CACHE_MEM_BRIDGE_TIMEOUT_EN to enable the TIMEOUT-cycle watchdog
// (otherwise the bridge waits indefinitely and err stays 0).
module cache_mem_bridge #(
  parameter int PA_WIDTH   = 32,
  parameter int LINE_WIDTH = 512,
  parameter int BUS_WIDTH  = 32,
  parameter int BO_WIDTH   = 6,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_rd,
  input  logic [PA_WIDTH-1:0]   req_rd_addr,
  input  logic                  req_wr,
  input  logic [PA_WIDTH-1:0]   req_wr_addr,
  input  logic [LINE_WIDTH-1:0] req_wr_data,
  output logic                  busy,
  output logic [LINE_WIDTH-1:0] line_data,
  output logic                  line_valid,
  output logic                  wr_done,
  output logic                  err,
  output logic                  bus_valid,
  output logic                  bus_we,
  output logic [PA_WIDTH-1:0]   bus_addr,
  output logic [BUS_WIDTH-1:0]  bus_wdata,
  input  logic                  bus_ready,
  input  logic [BUS_WIDTH-1:0]  bus_rdata,
  input  logic                  bus_rvalid
);
  localparam int TAG_W = PA_WIDTH - BO_WIDTH;
`ifdef CACHE_MEM_BRIDGE_TIMEOUT_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;
  state_t state, state_nx;
  logic [TAG_W-1:0] wr_base, rd_base;
  logic [LINE_WIDTH-1:0] wr_line;
  logic rd_pend, wb_first, done_wr, done_rd, done_err;
  logic [4:0] issue_cnt, rcv_cnt;
  logic [7:0] wd;
  logic hs, rx, active, last_wr, last_rx, timeout;
  logic [PA_WIDTH-1:0] beat_off;
  logic unused_offset_bits;
  assign unused_offset_bits = ^{req_rd_addr[BO_WIDTH-1:0], req_wr_addr[BO_WIDTH-1:0]};
  assign hs = bus_valid & bus_ready;
  // responses only count inside READ and only up to the 16th
  assign rx = (state == READ) & bus_rvalid & ~rcv_cnt[4];
  assign active = (state == WRITE) | (state == READ);
  assign last_wr = (state == WRITE) & hs & (issue_cnt == 5'd15);
  assign last_rx = rx & (rcv_cnt == 5'd15);
  assign timeout = WD_EN & active & ~hs & ~rx & (wd == 8'(TIMEOUT - 1));
  always_ff @(posedge clk) state <= !rst_n ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = req_wr ? WRITE : req_rd ? READ : IDLE;
      WRITE:   state_nx = timeout ? DONE : last_wr ? (rd_pend ? READ : DONE) : WRITE;
      READ:    state_nx = (timeout | last_rx) ? DONE : READ;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    busy = state != IDLE;
    bus_valid = (state == WRITE) | ((state == READ) & ~issue_cnt[4]);
    bus_we = state == WRITE;
    // beat offset stays below the line size, so the add never carries into the base
    beat_off = PA_WIDTH'({issue_cnt[3:0], 2'b00});
    bus_addr = !bus_valid ? '0 : bus_we ? {wr_base, BO_WIDTH'(0)} + beat_off : {rd_base, BO_WIDTH'(0)} + beat_off;
    bus_wdata = bus_we ? wr_line[BUS_WIDTH-1:0] : '0;
    line_valid = (state == DONE) & done_rd;
    wr_done = (state == DONE) & done_wr;
    err = (state == DONE) & done_err;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_base <= '0;
      rd_base <= '0;
      wr_line <= '0;
      rd_pend <= 1'b0;
      wb_first <= 1'b0;
      issue_cnt <= '0;
      rcv_cnt <= '0;
      wd <= '0;
      done_wr <= 1'b0;
      done_rd <= 1'b0;
      done_err <= 1'b0;
    end else begin
      wd <= (WD_EN & active & ~hs & ~rx) ? wd + 8'd1 : '0;
      if (state == IDLE) begin
        issue_cnt <= '0;
        rcv_cnt <= '0;
        done_wr <= 1'b0;
        done_rd <= 1'b0;
        done_err <= 1'b0;
        rd_pend <= req_wr & req_rd;
        wb_first <= req_wr & req_rd;
        if (req_wr) begin
          wr_base <= req_wr_addr[PA_WIDTH-1:BO_WIDTH];
          wr_line <= req_wr_data;
        end
        if (req_rd) rd_base <= req_rd_addr[PA_WIDTH-1:BO_WIDTH];
      end
      // the victim line shifts down so the current write word is always at the bottom
      if (hs) begin
        issue_cnt <= last_wr ? '0 : issue_cnt + 5'd1;
        wr_line <= wr_line >> BUS_WIDTH;
      end
      if (last_wr) begin
        rd_pend <= 1'b0;
        done_wr <= ~rd_pend;
      end
      if (rx) rcv_cnt <= rcv_cnt + 5'd1;
      if (last_rx) begin
        done_rd <= 1'b1;
        done_wr <= wb_first;
      end
      if (timeout) done_err <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) line_data <= '0;
    else for (int i = 0; i < 16; i++)
      if (rx && rcv_cnt[3:0] == 4'(i)) line_data[i*BUS_WIDTH +: BUS_WIDTH] <= bus_rdata;
  end
endmodule

// File: tb/tb_cache_mem_bridge.sv
// tb_cache_mem_bridge: scoreboard bench for cache_mem_bridge with a behavioural memory model.
module tb_cache_mem_bridge;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_rd = 1'b0, req_wr = 1'b0;
  logic [31:0] req_rd_addr = '0, req_wr_addr = '0;
  logic [511:0] req_wr_data = '0;
  logic busy, line_valid, wr_done, err, bus_valid, bus_we;
  logic [511:0] line_data;
  logic [31:0] bus_addr, bus_wdata;
  logic bus_ready = 1'b0, bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = '0;
  int errors = 0, checks = 0, cyc = 0;
  typedef struct {logic we; logic [31:0] addr; logic [31:0] data;} beat_t;
  typedef struct {logic lv; logic wd; logic er; logic [511:0] line;} evt_t;
  typedef struct {logic [31:0] addr; int due;} rsp_t;
  beat_t exp_beats[$];
  evt_t exp_evts[$];
  rsp_t rq[$];
  int unsigned key = 0;
  int lat = 2, ready_mode = 0, rsp_cnt = 0, first_v = -1, err_cyc = 0;
  bit spurious = 1'b0;
  logic [511:0] last_line = '0;
  bit pend = 1'b0, p_we;
  logic [31:0] p_addr, p_wdata;

  cache_mem_bridge dut (
    .clk(clk), .rst_n(rst_n), .req_rd(req_rd), .req_rd_addr(req_rd_addr), .req_wr(req_wr),
    .req_wr_addr(req_wr_addr), .req_wr_data(req_wr_data), .busy(busy), .line_data(line_data),
    .line_valid(line_valid), .wr_done(wr_done), .err(err), .bus_valid(bus_valid), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata),
    .bus_rvalid(bus_rvalid)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [511:0] act, logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // memory side: ready pattern and in-order read responses with fixed latency
  initial forever begin
    @(posedge clk);
    cyc++;
    #2;
    bus_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? ~bus_ready :
                ready_mode == 2 ? 1'($urandom_range(0, 1)) : 1'b0;
    if (!rst_n) begin
      rq.delete();
      bus_rvalid = 1'b0;
    end else if (spurious) begin
      bus_rvalid = 1'b1;
      bus_rdata = 32'hDEAD;
    end else if (rq.size() > 0 && rq[0].due <= cyc) begin
      bus_rvalid = 1'b1;
      bus_rdata = rq[0].addr ^ key;
      rq.pop_front();
      rsp_cnt++;
    end else begin
      bus_rvalid = 1'b0;
      bus_rdata = $urandom;
    end
  end

  // monitor: compares every handshake and completion pulse against the scoreboard
  initial forever begin
    beat_t b;
    evt_t e;
    @(negedge clk);
    if (!rst_n) pend = 1'b0;
    else begin
      if (pend && !err) begin
        chk("hold_valid", bus_valid, 1'b1);
        chk("hold_addr", bus_addr, p_addr);
        chk("hold_we", bus_we, p_we);
        if (p_we) chk("hold_wdata", bus_wdata, p_wdata);
      end
      pend = bus_valid && !bus_ready;
      p_we = bus_we;
      p_addr = bus_addr;
      p_wdata = bus_wdata;
      if (bus_valid && first_v < 0) first_v = cyc;
      if (bus_valid && bus_ready) begin
        if (exp_beats.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: addr %h we %b, none expected", bus_addr, bus_we);
        end else begin
          b = exp_beats.pop_front();
          chk("beat_we", bus_we, b.we);
          chk("beat_addr", bus_addr, b.addr);
          if (b.we) chk("beat_wdata", bus_wdata, b.data);
          if (!bus_we) rq.push_back('{bus_addr, cyc + lat});
        end
      end
      if (err) err_cyc = cyc;
      if (line_valid || wr_done || err) begin
        if (exp_evts.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: lv %b wd %b err %b, none expected", line_valid, wr_done, err);
        end else begin
          e = exp_evts.pop_front();
          chk("line_valid", line_valid, e.lv);
          chk("wr_done", wr_done, e.wd);
          chk("err", err, e.er);
          if (e.lv) chk("line_data", line_data, e.line);
        end
      end
    end
  end

  task automatic txn_start(bit w, bit r, logic [31:0] wa, logic [31:0] ra, logic [511:0] wl, bit to);
    logic [31:0] wb, rb;
    logic [511:0] ln = '0;
    wb = wa & ~32'h3f;
    rb = ra & ~32'h3f;
    for (int k = 0; k < 16; k++)
      if (w && !to) exp_beats.push_back('{1'b1, wb + 32'(4 * k), wl[32*k +: 32]});
    for (int k = 0; k < 16; k++) begin
      ln[32*k +: 32] = (rb + 32'(4 * k)) ^ key;
      if (r && !to) exp_beats.push_back('{1'b0, rb + 32'(4 * k), 32'h0});
    end
    exp_evts.push_back('{r && !to, w && !to, to, ln});
    if (r && !to) last_line = ln;
    first_v = -1;
    @(posedge clk);
    #1;
    req_wr = w;
    req_rd = r;
    req_wr_addr = wa;
    req_rd_addr = ra;
    req_wr_data = wl;
    @(posedge clk);
    #1;
    req_wr = 1'b0;
    req_rd = 1'b0;
    @(negedge clk);
    chk("busy_start", busy, 1'b1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_after_txn", busy, 1'b0);
    chk("beats_left", exp_beats.size(), 0);
    chk("pulses_left", exp_evts.size(), 0);
  endtask

  task automatic txn(bit w, bit r, logic [31:0] wa, logic [31:0] ra, logic [511:0] wl);
    txn_start(w, r, wa, ra, wl, 1'b0);
    wait_idle();
  endtask

  initial begin
    logic [511:0] wl;
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_bus_valid", bus_valid, 1'b0);
    chk("rst_pulses", {line_valid, wr_done, err}, 3'b000);
    chk("rst_line_data", line_data, '0);
    chk("rst_bus_addr", bus_addr, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // fill at 0x1234, zero-wait bus, latency 2, rdata = address
    key = 0;
    lat = 2;
    ready_mode = 0;
    txn(1'b0, 1'b1, 32'h0, 32'h0000_1234, '0);
    chk("fill_word5", line_data[191:160], 32'h1214);
    // writeback at 0x8040 with ready toggling
    for (int k = 0; k < 16; k++) wl[32*k +: 32] = 32'hA0 + 32'(k);
    ready_mode = 1;
    txn(1'b1, 1'b0, 32'h0000_8040, 32'h0, wl);
    // writeback and fill together
    key = $urandom;
    lat = 3;
    ready_mode = 2;
    for (int k = 0; k < 16; k++) wl[32*k +: 32] = $urandom;
    txn(1'b1, 1'b1, 32'h100, 32'h200, wl);
    // reset after seven read responses, then a fresh fill
    key = $urandom;
    lat = 1;
    ready_mode = 0;
    rsp_cnt = 0;
    txn_start(1'b0, 1'b1, 32'h0, 32'h0000_4000, '0, 1'b0);
    n = 0;
    while (rsp_cnt < 7 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("seven_responses", rsp_cnt >= 7, 1'b1);
    #1;
    rst_n = 1'b0;
    exp_beats.delete();
    exp_evts.delete();
    @(negedge clk);
    @(negedge clk);
    chk("abort_bus_valid", bus_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_line_data", line_data, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    key = $urandom;
    txn(1'b0, 1'b1, 32'h0, 32'h0000_4000, '0);
    // spurious responses while idle
    @(posedge clk);
    #1;
    spurious = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    spurious = 1'b0;
    @(negedge clk);
    chk("spurious_line_data", line_data, last_line);
    chk("spurious_busy", busy, 1'b0);
    // randomized mix
    for (int t = 0; t < 8; t++) begin
      int m;
      m = $urandom_range(1, 3);
      key = $urandom;
      lat = $urandom_range(1, 4);
      ready_mode = $urandom_range(0, 2);
      for (int k = 0; k < 16; k++) wl[32*k +: 32] = $urandom;
      txn(m[0], m[1], $urandom, $urandom, wl);
    end
`ifdef CACHE_MEM_BRIDGE_TIMEOUT_EN
    ready_mode = 3;
    repeat (2) @(posedge clk);
    txn_start(1'b0, 1'b1, 32'h0, 32'h0000_3000, '0, 1'b1);
    wait_idle();
    chk("timeout_latency", 32'(err_cyc - first_v), 32'd255);
    ready_mode = 0;
`endif
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule
